uart_receiver: RTL and testbench

UART serial receiver: 8N1-style framing, LSB first, 16x oversampling. Consumes the per-sample enable tick from the baud rate generator (ClockTick, wired here to SampleTick). Recovers bytes from the RxD line and presents each one with a single-cycle valid strobe. Sits between the pin-level RxD input and the byte-wide receive path.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_2ff.sv | 16 +
 rtl/uart_receiver.sv | 110 +++++++++++
 tb/tb_uart_receiver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and default frame constants, shared with the future uart_transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int UART_DEFAULT_DATA_BITS = 8;
  localparam int UART_DEFAULT_SAMPLE_RATE = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with a parameterised reset value
// Ports: clk, rst_n (sync active-low), d (async input), q (synchronized output)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) {q, meta} <= {RESET_VAL, RESET_VAL};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver, LSB first, start/data/stop framing
// Ports: Clock, ClearN (sync active-low), SampleTick (oversample enable), RxD (async line, idle high),
//        DataOut (last good byte), DataValid / FrameError (one-cycle strobes), Busy (not IDLE)
// Optional UART_RX_PARITY_EN: adds a PARITY state, parameter PARITY_ODD and the ParityError strobe
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DEFAULT_DATA_BITS,
  parameter int SAMPLE_RATE = UART_DEFAULT_SAMPLE_RATE
`ifdef UART_RX_PARITY_EN
  , parameter logic PARITY_ODD = 1'b0
`endif
) (
  input  logic                 Clock,
  input  logic                 ClearN,
  input  logic                 SampleTick,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] DataOut,
  output logic                 DataValid,
  output logic                 FrameError,
  output logic                 Busy
`ifdef UART_RX_PARITY_EN
  , output logic               ParityError
`endif
);
  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic rxs, par_err, good;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(Clock), .rst_n(ClearN), .d(RxD), .q(rxs));
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_err = par_bit != (^shreg ^ PARITY_ODD);
`else
  assign par_err = 1'b0;
`endif
  assign good = rxs && !par_err;
  assign Busy = state != IDLE;
  // Every sample point sits on tick count LAST after aligning to the start-bit midpoint,
  // so the STOP decision (and the return to IDLE) lands mid stop bit.
  always_ff @(posedge Clock) begin
    if (!ClearN) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      DataOut <= '0;
      DataValid <= 1'b0;
      FrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ParityError <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      DataValid <= 1'b0;
      FrameError <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ParityError <= 1'b0;
`endif
      if (SampleTick) begin
        case (state)
          IDLE: if (!rxs) begin
            state <= START;
            tick <= '0;
          end
          START: if (tick == MID) begin
            state <= rxs ? IDLE : DATA;
            tick <= '0;
            bit_cnt <= '0;
          end else tick <= tick + 1'b1;
          DATA: if (tick == LAST) begin
            tick <= '0;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= AFTER_DATA;
          end else tick <= tick + 1'b1;
`ifdef UART_RX_PARITY_EN
          PARITY: if (tick == LAST) begin
            tick <= '0;
            par_bit <= rxs;
            state <= STOP;
          end else tick <= tick + 1'b1;
`endif
          STOP: if (tick == LAST) begin
            tick <= '0;
            state <= IDLE;
            DataValid <= good;
            FrameError <= !rxs;
`ifdef UART_RX_PARITY_EN
            ParityError <= par_err;
`endif
            if (good) DataOut <= shreg;
          end else tick <= tick + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a frame-level reference model
module tb_uart_receiver;
  localparam int SR = 16;
  logic clk = 1'b0;
  logic ClearN, SampleTick, RxD;
  logic [7:0] DataOut;
  logic DataValid, FrameError, Busy;
`ifdef UART_RX_PARITY_EN
  logic ParityError;
`endif
  uart_receiver #(.DATA_BITS(8), .SAMPLE_RATE(SR)) dut (
    .Clock(clk), .ClearN(ClearN), .SampleTick(SampleTick), .RxD(RxD),
    .DataOut(DataOut), .DataValid(DataValid), .FrameError(FrameError), .Busy(Busy)
`ifdef UART_RX_PARITY_EN
    , .ParityError(ParityError)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int nv = 0, nf = 0, np = 0, both = 0, run = 0, max_run = 0, busy_cycles = 0;
  int exp_v = 0, exp_f = 0, exp_p = 0;
  int div = 1;
  logic [7:0] exp_out = 8'h00;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  always @(negedge clk) begin
    if (DataValid) begin
      nv++;
      got.push_back(DataOut);
    end
    if (FrameError) nf++;
`ifdef UART_RX_PARITY_EN
    if (ParityError) np++;
`endif
    if (DataValid && FrameError) both++;
    run = (DataValid || FrameError) ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (Busy) busy_cycles++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic one_tick();
    SampleTick = 1'b0;
    repeat (div - 1) @(negedge clk);
    SampleTick = 1'b1;
    @(negedge clk);
  endtask
  task automatic send_bit(input logic v);
    RxD = v;
    repeat (SR) one_tick();
  endtask
  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) one_tick();
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par);
    logic perr;
    perr = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
    perr = par != ^b;
    if (perr) exp_p++;
`else
    perr = perr & par;
`endif
    send_bit(stop_bit);
    if (!stop_bit) exp_f++;
    if (stop_bit && !perr) begin
      exp_v++;
      exp_out = b;
      exp_q.push_back(b);
    end
  endtask
  task automatic check_counts(input string tag);
    check({tag, "_valid"}, nv, exp_v);
    check({tag, "_ferr"}, nf, exp_f);
    check({tag, "_perr"}, np, exp_p);
    check({tag, "_dout"}, DataOut, exp_out);
    check({tag, "_busy"}, Busy, 1'b0);
  endtask
  initial begin
    logic [7:0] b;
    logic s;
    ClearN = 1'b0;
    RxD = 1'b1;
    SampleTick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", DataOut, 8'h00);
    check("rst_valid", DataValid, 1'b0);
    check("rst_ferr", FrameError, 1'b0);
    check("rst_busy", Busy, 1'b0);
    ClearN = 1'b1;
    idle(8);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(32);
    check_counts("a5");
    busy_cycles = 0;
    RxD = 1'b0;
    repeat (4) one_tick();
    idle(32);
    check("glitch_busy_min", busy_cycles >= 4, 1'b1);
    check("glitch_busy_max", busy_cycles <= 10, 1'b1);
    check_counts("glitch");
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(32);
    check_counts("badstop");
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      s = $urandom_range(0, 3) != 0;
      send_frame(b, s, ^b ^ ($urandom_range(0, 3) == 0));
      idle(32);
      check_counts("rand");
    end
    SampleTick = 1'b0;
    RxD = 1'b0;
    repeat (40) @(negedge clk);
    check("frozen_busy", Busy, 1'b0);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
    idle(8);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    RxD = 1'b1;
    ClearN = 1'b0;
    @(negedge clk);
    ClearN = 1'b1;
    exp_out = 8'h00;
    check("midrst_dout", DataOut, 8'h00);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_valid", DataValid, 1'b0);
    idle(40);
    check_counts("midrst");
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(32);
    check_counts("5a");
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(32);
    check_counts("par_ok");
    send_frame(8'h07, 1'b1, 1'b0);
    idle(32);
    check_counts("par_bad");
`endif
    div = 163;
    idle(4);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(12);
    check_counts("b2b");
    check("queue_len", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) check("queue_byte", got[i], exp_q[i]);
    check("strobe_width", max_run, 1);
    check("strobe_overlap", both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
